// File: rtl/counter_pkg.sv
// Shared constants for the lab counter family: direction encodings and the
// default width/top used by the lab top levels.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int unsigned W_DEF   = 5;
  localparam int unsigned TOP_DEF = 24;

endpackage

// File: rtl/ce_prescaler.sv
// Clock-enable prescaler: emits a one-cycle tick once every PRESCALE enabled
// cycles. The phase only advances while en is high; clr restarts the phase.
module ce_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic ck,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // Keep a 1-bit phase for PRESCALE=1 so the register never has zero width.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PhaseLast = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q, phase_d;

  assign tick = en && (phase_q == PhaseLast);

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = tick ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with programmable top value, synchronous load,
// built-in clock-enable prescaler and a registered terminal-count pulse.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned TOP_RST  = TOP_DEF,
  parameter int unsigned PRESCALE = 1
) (
  input  logic         ck,
  input  logic         rs,
  input  logic         en,
  input  logic         dir,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         ld_top,
  input  logic [W-1:0] top_in,
  output logic [W-1:0] q,
  output logic         tc,
  output logic [W-1:0] top
);

  localparam logic [W-1:0] TopRst = W'(TOP_RST);

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] top_q, top_d;
  logic         tc_q, tc_d;
  logic         tick;

  ce_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .ck   (ck),
    .rs   (rs),
    .en   (en),
    .clr  (ld),
    .tick (tick)
  );

  // Load and step both use the pre-update top; a new top applies next cycle.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    top_d = ld_top ? top_in : top_q;
    if (ld) begin
      q_d = (d > top_q) ? top_q : d;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        // >= so a q stranded above a lowered top wraps on the next step.
        if (q_q >= top_q) begin
          q_d  = '0;
          tc_d = 1'b1;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q == '0) begin
          q_d  = top_q;
          tc_d = 1'b1;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      q_q   <= TopRst;
      top_q <= TopRst;
      tc_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      top_q <= top_d;
      tc_q  <= tc_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign top = top_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: a PRESCALE=1 and a PRESCALE=4 instance share
// stimulus; both are checked every cycle against a behavioural model.
module tb_mod_updown_counter;
  import counter_pkg::*;

  logic       ck = 1'b0;
  logic       rs = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       ld = 1'b0;
  logic       ld_top = 1'b0;
  logic [4:0] d = '0;
  logic [4:0] top_in = '0;

  logic [4:0] q0, top0, q1, top1;
  logic       tc0, tc1;

  int total = 0;
  int bad = 0;

  // Model state per instance: count value, top, tc, enabled cycles since clear.
  int mq[2];
  int mtop[2];
  int mtc[2];
  int mcnt[2];
  int pre[2] = '{1, 4};

  always #5 ck = ~ck;

  mod_updown_counter u_dut0 (
    .ck     (ck),
    .rs     (rs),
    .en     (en),
    .dir    (dir),
    .ld     (ld),
    .d      (d),
    .ld_top (ld_top),
    .top_in (top_in),
    .q      (q0),
    .tc     (tc0),
    .top    (top0)
  );

  mod_updown_counter #(
    .PRESCALE (4)
  ) u_dut1 (
    .ck     (ck),
    .rs     (rs),
    .en     (en),
    .dir    (dir),
    .ld     (ld),
    .d      (d),
    .ld_top (ld_top),
    .top_in (top_in),
    .q      (q1),
    .tc     (tc1),
    .top    (top1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i]   = 24;
      mtop[i] = 24;
      mtc[i]  = 0;
      mcnt[i] = 0;
    end
  endfunction

  // Applies one rising edge to the model using the currently driven inputs.
  function automatic void model_edge();
    if (rs) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit tk;
      int new_top;
      tk      = en && (((mcnt[i] + 1) % pre[i]) == 0);
      new_top = ld_top ? int'(top_in) : mtop[i];
      if (ld) begin
        mq[i]   = (int'(d) > mtop[i]) ? mtop[i] : int'(d);
        mtc[i]  = 0;
        mcnt[i] = 0;
      end else begin
        if (en) mcnt[i]++;
        mtc[i] = 0;
        if (tk) begin
          if (dir == DIR_UP) begin
            if (mq[i] >= mtop[i]) begin
              mq[i]  = 0;
              mtc[i] = 1;
            end else begin
              mq[i] = mq[i] + 1;
            end
          end else begin
            if (mq[i] == 0) begin
              mq[i]  = mtop[i];
              mtc[i] = 1;
            end else begin
              mq[i] = mq[i] - 1;
            end
          end
        end
      end
      mtop[i] = new_top;
    end
  endfunction

  task automatic check_all();
    chk("q0",   8'(q0),   8'(mq[0]));
    chk("tc0",  8'(tc0),  8'(mtc[0]));
    chk("top0", 8'(top0), 8'(mtop[0]));
    chk("q1",   8'(q1),   8'(mq[1]));
    chk("tc1",  8'(tc1),  8'(mtc[1]));
    chk("top1", 8'(top1), 8'(mtop[1]));
  endtask

  task automatic cyc();
    @(posedge ck);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    model_reset();
    #2 rs = 1'b1;
    #1;
    check_all();
    chk("rst_q", 8'(q0), 8'd24);
    run(10);

    // Down count from reset and wrap back to top.
    rs = 1'b0; en = 1'b1; dir = DIR_DOWN;
    run(24);
    chk("down_zero", 8'(q0), 8'd0);
    cyc();
    chk("down_wrap_q", 8'(q0), 8'd24);
    chk("down_wrap_tc", 8'(tc0), 8'd1);
    cyc();
    chk("down_tc_drop", 8'(tc0), 8'd0);
    chk("down_after_wrap", 8'(q0), 8'd23);

    // New top 9 and up wrap from 0.
    ld_top = 1'b1; top_in = 5'd9; ld = 1'b1; d = 5'd0; dir = DIR_UP;
    cyc();
    chk("top9_visible", 8'(top0), 8'd9);
    chk("load0", 8'(q0), 8'd0);
    ld_top = 1'b0; ld = 1'b0;
    run(9);
    chk("up_at_top", 8'(q0), 8'd9);
    cyc();
    chk("up_wrap_q", 8'(q0), 8'd0);
    chk("up_wrap_tc", 8'(tc0), 8'd1);

    // Load clamp and load-over-step priority.
    ld_top = 1'b1; top_in = 5'd24;
    cyc();
    ld_top = 1'b0; ld = 1'b1; d = 5'd30;
    cyc();
    chk("clamp_q", 8'(q0), 8'd24);
    chk("clamp_tc", 8'(tc0), 8'd0);
    ld = 1'b0; dir = DIR_DOWN;
    cyc();
    chk("after_clamp", 8'(q0), 8'd23);

    // Async reset between edges while q=13 and top=15.
    ld = 1'b1; d = 5'd13; ld_top = 1'b1; top_in = 5'd15;
    cyc();
    ld = 1'b0; ld_top = 1'b0; en = 1'b0;
    chk("pre_rst_q", 8'(q0), 8'd13);
    #2 rs = 1'b1;
    #1;
    model_reset();
    chk("async_q", 8'(q0), 8'd24);
    chk("async_top", 8'(top0), 8'd24);
    chk("async_tc", 8'(tc0), 8'd0);
    check_all();
    en = 1'b1; ld_top = 1'b1; top_in = 5'd5; ld = 1'b1; d = 5'd3;
    run(3);
    chk("rst_hold_q", 8'(q0), 8'd24);
    chk("rst_hold_top", 8'(top0), 8'd24);

    // Prescaler timing on the PRESCALE=4 instance.
    ld_top = 1'b0; ld = 1'b0; dir = DIR_DOWN; rs = 1'b0;
    run(3);
    chk("pre_c3", 8'(q1), 8'd24);
    cyc();
    chk("pre_c4", 8'(q1), 8'd23);
    run(3);
    chk("pre_c7", 8'(q1), 8'd23);
    cyc();
    chk("pre_c8", 8'(q1), 8'd22);
    run(2);
    en = 1'b0;
    run(3);
    en = 1'b1;
    cyc();
    chk("pre_c14", 8'(q1), 8'd22);
    cyc();
    chk("pre_c15", 8'(q1), 8'd21);
    run(2);
    ld = 1'b1; d = 5'd5;
    cyc();
    chk("pre_ld", 8'(q1), 8'd5);
    ld = 1'b0;
    run(3);
    chk("pre_ld_c3", 8'(q1), 8'd5);
    cyc();
    chk("pre_ld_c4", 8'(q1), 8'd4);

    // Top lowered below q: down runs through, up wraps immediately.
    ld = 1'b1; d = 5'd20; ld_top = 1'b1; top_in = 5'd10; dir = DIR_DOWN;
    cyc();
    chk("low_q", 8'(q0), 8'd20);
    chk("low_top", 8'(top0), 8'd10);
    ld = 1'b0; ld_top = 1'b0;
    run(20);
    chk("low_down_zero", 8'(q0), 8'd0);
    cyc();
    chk("low_down_wrap", 8'(q0), 8'd10);
    chk("low_down_tc", 8'(tc0), 8'd1);
    ld_top = 1'b1; top_in = 5'd24;
    cyc();
    ld = 1'b1; d = 5'd20; ld_top = 1'b1; top_in = 5'd10;
    cyc();
    chk("low_up_q", 8'(q0), 8'd20);
    ld = 1'b0; ld_top = 1'b0; dir = DIR_UP;
    cyc();
    chk("low_up_wrap", 8'(q0), 8'd0);
    chk("low_up_tc", 8'(tc0), 8'd1);

    // Randomized traffic, including small tops (0 included) and stray resets.
    for (int n = 0; n < 400; n++) begin
      en     = ($urandom % 4) != 0;
      dir    = 1'($urandom);
      ld     = ($urandom % 8) == 0;
      d      = 5'($urandom);
      ld_top = ($urandom % 10) == 0;
      top_in = (($urandom % 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      if (($urandom % 97) == 0) begin
        #2 rs = 1'b1;
        #1;
        model_reset();
        check_all();
        cyc();
        rs = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
